// File: rtl/gfx_serial_pkg.sv
// Shared constants and state encodings for the serial receive path into VRAM.
package gfx_serial_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam int         VRAM_ADDR_W = 11;
    localparam int         VRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        FR_HUNT,
        FR_HI,
        FR_LO
    } frame_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 byte receiver: line synchronizer, mid-bit sampling and stop-bit check.
module uart_rx_core
    import gfx_serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       framing_err_o,
    output logic       rx_idle_o
);

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_meta_q;
    logic             rx_sync_q;
    logic             rx_prev_q;
    rx_state_e        state_q;
    logic [CNT_W-1:0] baud_cnt_q;
    logic [CNT_W-1:0] baud_cnt_d;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic             bit_tick;
    logic             half_tick;

    assign baud_cnt_d = baud_cnt_q + CNT_W'(1);
    assign bit_tick   = (baud_cnt_q == BIT_LAST);
    assign half_tick  = (baud_cnt_q == HALF_LAST);

    // Byte results are combinational in the stop-sample cycle so the frame
    // layer can register the write exactly one cycle later.
    assign byte_valid_o  = (state_q == RX_STOP) && bit_tick && rx_sync_q;
    assign framing_err_o = (state_q == RX_STOP) && bit_tick && !rx_sync_q;
    assign byte_data_o   = shift_q;
    assign rx_idle_o     = (state_q == RX_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            state_q    <= RX_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            case (state_q)
                RX_IDLE: begin
                    baud_cnt_q <= '0;
                    if (rx_prev_q && !rx_sync_q) begin
                        state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (half_tick) begin
                        baud_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        state_q    <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_d;
                    end
                end
                RX_DATA: begin
                    if (bit_tick) begin
                        baud_cnt_q <= '0;
                        shift_q    <= {rx_sync_q, shift_q[7:1]};
                        bit_cnt_q  <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_d;
                    end
                end
                RX_STOP: begin
                    if (bit_tick) begin
                        baud_cnt_q <= '0;
                        state_q    <= RX_IDLE;
                    end else begin
                        baud_cnt_q <= baud_cnt_d;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/gfx_serial_receiver.sv
// Frame decoder: hunts for the sync byte, assembles big-endian 16-bit words
// and writes them sequentially into a VRAM-shaped write port.
module gfx_serial_receiver
    import gfx_serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FRAME_WORDS  = 2048,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   IN_SERIAL_RX,
    output logic                   WR_ENABLE,
    output logic [VRAM_ADDR_W-1:0] WR_ADDR,
    output logic [VRAM_DATA_W-1:0] WR_DATA,
    output logic                   FRAME_DONE,
    output logic                   BUSY,
    output logic                   ERR
);

    localparam int                     TMO_CYCLES = CLKS_PER_BIT * TIMEOUT_BITS;
    localparam int                     TMO_W      = $clog2(TMO_CYCLES);
    localparam logic [TMO_W-1:0]       TMO_LAST   = TMO_W'(TMO_CYCLES - 1);
    localparam logic [VRAM_ADDR_W-1:0] LAST_ADDR  = VRAM_ADDR_W'(FRAME_WORDS - 1);

    logic                   byte_valid;
    logic [7:0]             byte_data;
    logic                   framing_err;
    logic                   rx_idle;

    frame_state_e           state_q;
    logic [VRAM_ADDR_W-1:0] addr_q;
    logic [VRAM_ADDR_W-1:0] addr_d;
    logic [7:0]             hi_q;
    logic [TMO_W-1:0]       tmo_q;
    logic [TMO_W-1:0]       tmo_d;
    logic                   tmo_expired;
    logic                   wr_en_q;
    logic [VRAM_ADDR_W-1:0] wr_addr_q;
    logic [VRAM_DATA_W-1:0] wr_data_q;
    logic                   done_q;
    logic                   busy_q;
    logic                   err_q;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_core (
        .clk           (CLK),
        .rst_n         (RESET),
        .rx_i          (IN_SERIAL_RX),
        .byte_valid_o  (byte_valid),
        .byte_data_o   (byte_data),
        .framing_err_o (framing_err),
        .rx_idle_o     (rx_idle)
    );

    assign addr_d = addr_q + VRAM_ADDR_W'(1);
    assign tmo_d  = tmo_q + TMO_W'(1);
    // The idle timer only advances while no byte is in flight, so it measures
    // true line silence rather than time spent receiving a byte.
    assign tmo_expired = rx_idle && (tmo_q == TMO_LAST);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= FR_HUNT;
            addr_q    <= '0;
            hi_q      <= '0;
            tmo_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                FR_HUNT: begin
                    tmo_q <= '0;
                    if (byte_valid && (byte_data == SYNC_BYTE)) begin
                        busy_q  <= 1'b1;
                        addr_q  <= '0;
                        state_q <= FR_HI;
                    end
                end
                FR_HI, FR_LO: begin
                    if (framing_err || tmo_expired) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= FR_HUNT;
                    end else if (byte_valid) begin
                        tmo_q <= '0;
                        if (state_q == FR_HI) begin
                            hi_q    <= byte_data;
                            state_q <= FR_LO;
                        end else begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= addr_q;
                            wr_data_q <= {hi_q, byte_data};
                            addr_q    <= addr_d;
                            if (addr_q == LAST_ADDR) begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= FR_HUNT;
                            end else begin
                                state_q <= FR_HI;
                            end
                        end
                    end else if (rx_idle) begin
                        tmo_q <= tmo_d;
                    end
                end
                default: state_q <= FR_HUNT;
            endcase
        end
    end

    assign WR_ENABLE  = wr_en_q;
    assign WR_ADDR    = wr_addr_q;
    assign WR_DATA    = wr_data_q;
    assign FRAME_DONE = done_q;
    assign BUSY       = busy_q;
    assign ERR        = err_q;

endmodule
